// File: rtl/fault_event_log.sv
// Timestamped fault event recorder with a first-word-fall-through queue.
// Edge-detects fault codes and the co-processor flag; overflow is sticky.
module fault_event_log #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               fault_code,
    input  logic [1:0]               fault_class,
    input  logic                     cp_flag,
    input  logic                     pop,
    input  logic                     clr,
    output logic                     evt_valid,
    output logic [5+TS_W:0]          evt_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 6 + TS_W;

    logic [2:0]      prev_code_q, prev_code_d;
    logic            prev_cp_q, prev_cp_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];

    logic            code_evt;
    logic            cp_evt;
    logic            evt;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            drop;
    logic [EW-1:0]   entry;

    always_comb begin
        code_evt = (fault_code != 3'd0) && (fault_code != prev_code_q);
        cp_evt   = cp_flag && !prev_cp_q;
        evt      = code_evt || cp_evt;
        entry    = {cp_evt, fault_class, fault_code, ts_q};
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && (count_q != '0);
        do_push  = evt && (!full || do_pop);
        drop     = evt && full && !do_pop;
    end

    always_comb begin
        prev_code_d = fault_code;
        prev_cp_d   = cp_flag;
        ts_d        = ts_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        mem_d       = mem_q;
        if (clr) begin
            ts_d       = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            ts_d = ts_q + TS_W'(1);
            if (do_push) begin
                mem_d[wr_ptr_q] = entry;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            // simultaneous push and pop leave the occupancy unchanged
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_code_q <= '0;
            prev_cp_q   <= 1'b0;
            ts_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            prev_code_q <= prev_code_d;
            prev_cp_q   <= prev_cp_d;
            ts_q        <= ts_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            mem_q       <= mem_d;
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_data  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/fault_event_log.md
# fault_event_log

Downstream event recorder for the fault-protection datapath. It watches the 3-bit fault code and 2-bit fault class from `fault_pro` and the single-bit flag from `co_processor`, and timestamps each new fault event. Events go into a small first-word-fall-through FIFO that host logic drains with a pop strobe. Overflow is flagged sticky so no lost event goes unnoticed.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `TS_W`, 8: timestamp counter width.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fault_code`  in  3  fault code from `fault_pro.out`.
- `fault_class`  in  2  fault class from `fault_pro.out1`.
- `cp_flag`  in  1  status flag from `co_processor.Q`.
- `pop`  in  1  remove head entry; honoured only while `evt_valid`=1.
- `clr`  in  1  synchronous clear of FIFO, overflow and timestamp.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_data`  out  6+TS_W  head entry `{cp_evt, fault_class, fault_code, ts}`, MSB first; all zeros when empty.
- `count`  out  clog2(DEPTH)+1  number of stored entries.
- `overflow`  out  1  sticky; an event was dropped.

## Operation
- Reset behaviour:
  - `prev_code` resets to 0 and `prev_cp` resets to 0.
  - The timestamp `ts` resets to 0.
  - Read and write pointers reset to 0.
  - Outputs reset to: `evt_valid`=0, `evt_data`=0, `count`=0, `overflow`=0.
- Timestamp:
  - `ts` increments by 1 every cycle.
  - It wraps from 2^TS_W−1 to 0.
  - `clr` forces `ts` to 0.
- Event detection, sampled every cycle:
  - `code_evt` = (`fault_code`≠0) && (`fault_code`≠`prev_code`).
  - `cp_evt` = `cp_flag` && !`prev_cp`.
  - `event` = `code_evt` || `cp_evt`.
  - `prev_code` and `prev_cp` load the current inputs every cycle, including during `clr`.
- Entry format:
  - An entry holds `{cp_evt, fault_class, fault_code, ts}`, all taken from the same sampling cycle.
  - A code event and a cp event in the same cycle produce one entry with `cp_evt`=1.
  - A cp-only event stores the current `fault_code`, which may be 0.
- A steady nonzero `fault_code` logs once.
  - A return to 0 followed by the same nonzero code logs again.
- Priority of operations within one cycle:
  - `clr` wins: pointers, `count`, `overflow` and `ts` are cleared, and any push or pop in that cycle is discarded.
  - Otherwise, a pop occurs when `pop` && `evt_valid`; `pop` while empty is ignored.
  - A push occurs when `event` && (`count`<DEPTH || pop occurs).
  - Push and pop in the same cycle are both performed and `count` is unchanged. This holds when full, so no overflow.
  - An event while full without a pop is dropped: the FIFO is unchanged and `overflow` is set to 1.
  - `overflow` stays set until `clr` or reset.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- `evt_data` presents the entry at the read pointer, forced to 0 when `count`=0.

## Timing
- Inputs and `pop` are sampled on the rising edge.
- An event sampled at edge N is visible at edge N+1:
  - `evt_valid`=1 and `count` incremented.
  - If the FIFO was empty, `evt_data` shows the new entry.
  - The stored `ts` is the value `ts` held during the cycle before edge N.
- A pop at edge N: the next entry, or zeros, appears in the cycle after edge N.
- `overflow` rises in the cycle after the dropping edge.
- All outputs are registered or decoded from registers only; there is no combinational input-to-output path.
- Reset assertion mid-operation:
  - All state clears immediately and asynchronously.
  - The first edge after deassertion samples against `prev_code`=0 and `prev_cp`=0. A nonzero `fault_code` held across reset therefore logs an event at that edge.

## Test plan
- Reset and idle:
  - Stimulus: assert `reset`=0 with inputs nonzero, then release with all inputs 0 for 10 cycles.
  - Required: `evt_valid`=0, `count`=0, `overflow`=0 and `evt_data`=0 throughout.
- Single event with FWFT read:
  - Stimulus: drive `fault_code`=3'b101 and `fault_class`=2'b10 at the cycle where `ts`=0x07; hold them for 5 cycles.
  - Required: exactly one entry, `evt_data`={0,10,101,0x07}, and `count`=1.
  - Stimulus: `pop`.
  - Required: `evt_valid`=0 on the next cycle.
- Coincident events:
  - Stimulus: `cp_flag` 0→1 in the same cycle `fault_code` goes 0→3'b011.
  - Required: one entry with `cp_evt`=1 and code 011.
  - Stimulus: hold `cp_flag`=1.
  - Required: no further entries.
- Fill and overflow:
  - Stimulus: 5 distinct events with no pop.
  - Required: `count`=4 and `overflow`=1, and the four stored entries are the first four events.
  - Stimulus: a sixth event with `pop` asserted in the same cycle.
  - Required: `count` stays 4 and the head advances.
- Timestamp wrap and clear:
  - Stimulus: an event at `ts`=0xFF, then another event one cycle later.
  - Required: stamps 0xFF and 0x00.
  - Stimulus: `clr` asserted together with an event and `pop`.
  - Required: `count`=0, `overflow`=0, `ts`=0 on the next cycle, and no entry stored.
- Reset mid-fill:
  - Stimulus: assert `reset` with 3 entries stored.
  - Required: immediate `count`=0 and `evt_valid`=0.
  - Stimulus: release with `fault_code`=3'b010 held.
  - Required: one entry logged with stamp 0x00.
